// File: rtl/sigmoid_sequencer_if.sv
// sigmoid_sequencer_if: operand and result valid/ready channels of the sigmoid sequencer
interface sigmoid_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/sigmoid_sequencer.sv
// sigmoid_sequencer: binary-to-bitstream job controller for one stochastic sigmoid datapath.
// Define SIGMOID_SEQ_ROUND_EN to round the result to nearest instead of truncating.
module sigmoid_sequencer #(
  parameter logic [7:0] SEED = 8'hB5,
  parameter int WARMUP = 16,
  parameter int LEN_LOG2 = 8
) (
  input  logic clk,
  input  logic rst,
  sigmoid_sequencer_if.slave bus,
  output logic busy,
  output logic dp_n_rst,
  output logic dp_x,
  input  logic dp_y
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WARM, S_ACCUM, S_DONE} state_t;
  localparam int SH = LEN_LOG2 - 8;
`ifdef SIGMOID_SEQ_ROUND_EN
  localparam logic [LEN_LOG2:0] RND = (LEN_LOG2+1)'((1 << LEN_LOG2) >> 9);
`else
  localparam logic [LEN_LOG2:0] RND = '0;
`endif
  state_t state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d, operand_q, operand_d, out_data_q, out_data_d;
  logic [LEN_LOG2-1:0] cnt_q, cnt_d;
  logic [LEN_LOG2:0] ones_q, ones_d, scaled;
  logic live, dp_n_rst_q, dp_n_rst_d, dp_x_q, dp_x_d, out_valid_q, out_valid_d;
  assign live = state_q == S_WARM || state_q == S_ACCUM;
  assign scaled = (ones_q + RND) >> SH;
  assign bus.in_ready = state_q == S_IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign busy = state_q != S_IDLE;
  assign dp_n_rst = dp_n_rst_q;
  assign dp_x = dp_x_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.in_valid ? S_CLEAR : S_IDLE;
      S_CLEAR: state_d = (WARMUP == 0) ? S_ACCUM : S_WARM;
      S_WARM:  state_d = (cnt_q == LEN_LOG2'(WARMUP - 1)) ? S_ACCUM : S_WARM;
      S_ACCUM: state_d = (&cnt_q) ? S_DONE : S_ACCUM;
      S_DONE:  state_d = (out_valid_q && bus.out_ready) ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // Outputs to the datapath and out_valid are registered from state_q, so they trail the state by one cycle
  always_comb begin
    lfsr_d = (state_q == S_CLEAR) ? SEED
           : live ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    cnt_d = (state_q == S_CLEAR || (state_q == S_WARM && state_d == S_ACCUM)) ? '0
          : live ? cnt_q + 1'b1 : cnt_q;
    ones_d = (state_q == S_CLEAR) ? '0
           : (state_q == S_ACCUM) ? ones_q + (LEN_LOG2+1)'(dp_y) : ones_q;
    operand_d = (state_q == S_IDLE && bus.in_valid) ? bus.in_data : operand_q;
    dp_n_rst_d = live;
    dp_x_d = live && (lfsr_q < operand_q);
    out_valid_d = state_q == S_DONE && !(out_valid_q && bus.out_ready);
    out_data_d = (state_q == S_DONE && !out_valid_q) ? ((|scaled[LEN_LOG2:8]) ? 8'hFF : scaled[7:0]) : out_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q <= SEED;
      cnt_q <= '0;
      ones_q <= '0;
      operand_q <= '0;
      dp_n_rst_q <= 1'b0;
      dp_x_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      ones_q <= ones_d;
      operand_q <= operand_d;
      dp_n_rst_q <= dp_n_rst_d;
      dp_x_q <= dp_x_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_sigmoid_sequencer.sv
// tb_sigmoid_sequencer: directed bench for the sigmoid sequencer with a bench-driven dp_y.
module tb_sigmoid_sequencer;
  logic clk = 0, rst = 1, tog = 0;
  logic busy, dp_n_rst, dp_x, dp_y, busy2, dp_n_rst2, dp_x2;
  logic [1:0] mode = 0;
  int n_pass = 0, n_total = 0;
  int lat, xones, nhigh;
  logic [7:0] res, res1;
  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;
  // mode: 0 = dp_y low, 1 = dp_y high, 2 = toggling, 3 = dp_y follows dp_x
  assign dp_y = (mode == 2'd3) ? dp_x : (mode == 2'd2) ? tog : mode[0];
  sigmoid_sequencer_if bus();
  sigmoid_sequencer_if bus2();
  sigmoid_sequencer u_dut (.clk(clk), .rst(rst), .bus(bus.slave), .busy(busy),
                           .dp_n_rst(dp_n_rst), .dp_x(dp_x), .dp_y(dp_y));
  sigmoid_sequencer #(.WARMUP(0), .LEN_LOG2(10)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave),
                           .busy(busy2), .dp_n_rst(dp_n_rst2), .dp_x(dp_x2), .dp_y(tog));

  task start_job(input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = 1;
    bus.in_data = d;
    for (int i = 0; i < 2000 && !bus.in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 bus.in_valid = 0;
  endtask

  task wait_result;
    lat = 0; xones = 0; nhigh = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      xones += int'(dp_x);
      nhigh += int'(dp_n_rst);
    end while (!bus.out_valid && lat < 2000);
    res = bus.out_data;
  endtask

  task consume;
    @(negedge clk);
    bus.out_ready = 1;
    @(posedge clk);
    #1 bus.out_ready = 0;
  endtask

  task test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if ({bus.out_valid, busy, dp_n_rst, dp_x} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {bus.out_valid, busy, dp_n_rst, dp_x}); else n_pass++;
    n_total++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", bus.out_data); else n_pass++;
    rst = 0;
  endtask

  task test_ones_latency;
    mode = 1;
    start_job(8'h40);
    wait_result;
    n_total++; if (lat !== 274) $display("FAIL ones_latency: got %0d want 274", lat); else n_pass++;
    n_total++; if (res !== 8'hFF) $display("FAIL ones_saturate: got %h want ff", res); else n_pass++;
    n_total++; if (nhigh !== 272) $display("FAIL ones_nrst_cycles: got %0d want 272", nhigh); else n_pass++;
    n_total++; if ({busy, bus.in_ready, dp_n_rst} !== 3'b100) $display("FAIL done_flags: got %b want 100", {busy, bus.in_ready, dp_n_rst}); else n_pass++;
    consume;
    n_total++; if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) $display("FAIL after_consume: got %b want 010", {bus.out_valid, bus.in_ready, busy}); else n_pass++;
    n_total++; if (bus.out_data !== 8'hFF) $display("FAIL out_data_hold: got %h want ff", bus.out_data); else n_pass++;
  endtask

  task test_zero_toggle;
    mode = 0;
    start_job(8'h80); wait_result; consume;
    n_total++; if (res !== 8'h00) $display("FAIL zeros_result: got %h want 00", res); else n_pass++;
    mode = 2;
    start_job(8'h80); wait_result; consume;
    n_total++; if (res !== 8'd128) $display("FAIL toggle_result: got %0d want 128", res); else n_pass++;
  endtask

  task test_dp_x;
    mode = 0;
    start_job(8'h00); wait_result; consume;
    n_total++; if (xones !== 0) $display("FAIL dpx_zero_operand: got %0d ones want 0", xones); else n_pass++;
    start_job(8'hFF); wait_result; consume;
    n_total++; if (xones < 270 || xones > 271) $display("FAIL dpx_full_operand: got %0d ones want 270..271", xones); else n_pass++;
  endtask

  task test_back_to_back;
    mode = 3;
    start_job(8'h80); wait_result; consume;
    res1 = res;
    n_total++; if (res1 < 8'd104 || res1 > 8'd152) $display("FAIL follow_half: got %0d want 104..152", res1); else n_pass++;
    start_job(8'h80); wait_result; consume;
    n_total++; if (res !== res1) $display("FAIL repeat_identical: got %0d want %0d", res, res1); else n_pass++;
    n_total++; if (lat !== 274) $display("FAIL repeat_latency: got %0d want 274", lat); else n_pass++;
  endtask

  task test_stall;
    int bad;
    bad = 0;
    mode = 1;
    start_job(8'h40); wait_result;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.in_data = 8'h11;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF || bus.in_ready !== 1'b0) bad++;
    end
    bus.in_valid = 0;
    n_total++; if (bad !== 0) $display("FAIL stall_stable: got %0d bad cycles want 0", bad); else n_pass++;
    consume;
    n_total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL stall_release: got %b want 01", {bus.out_valid, bus.in_ready}); else n_pass++;
  endtask

  task test_mid_reset;
    mode = 1;
    start_job(8'h40);
    repeat (117) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1 rst = 0;
    n_total++; if ({bus.out_valid, dp_n_rst, busy, bus.in_ready} !== 4'b0001) $display("FAIL mid_reset: got %b want 0001", {bus.out_valid, dp_n_rst, busy, bus.in_ready}); else n_pass++;
    start_job(8'h40); wait_result; consume;
    n_total++; if (lat !== 274 || res !== 8'hFF) $display("FAIL post_reset_job: got lat %0d res %h want 274 ff", lat, res); else n_pass++;
  endtask

  task test_len10_nowarmup;
    int l2, h2;
    l2 = 0; h2 = 0;
    @(negedge clk);
    bus2.in_valid = 1;
    bus2.in_data = 8'h80;
    @(posedge clk);
    #1 bus2.in_valid = 0;
    do begin
      @(posedge clk); #1;
      l2++;
      h2 += int'(dp_n_rst2);
    end while (!bus2.out_valid && l2 < 3000);
    n_total++; if (l2 !== 1026) $display("FAIL len10_latency: got %0d want 1026", l2); else n_pass++;
    n_total++; if (h2 !== 1024) $display("FAIL len10_nrst_cycles: got %0d want 1024", h2); else n_pass++;
    n_total++; if (bus2.out_data !== 8'd128) $display("FAIL len10_toggle: got %0d want 128", bus2.out_data); else n_pass++;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = 0; bus2.out_ready = 0;
    test_reset;
    test_ones_latency;
    test_zero_toggle;
    test_dp_x;
    test_back_to_back;
    test_stall;
    test_mid_reset;
    test_len10_nowarmup;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sigmoid_sequencer.md
Name: sigmoid_sequencer

Overview:
Job controller for one bitstream sigmoid datapath. Accepts an 8-bit binary operand over a valid/ready handshake and converts it to a stochastic bitstream with an internal LFSR comparator. It drives the datapath's active-low reset and x input, discards a warm-up window, then counts ones on the datapath's y output over a fixed window. The count is returned as an 8-bit binary result over a second valid/ready handshake, which makes the sigmoid usable from binary-domain network logic.

Parameters:
SEED, 8'hB5, LFSR reseed value at the start of each job; must be nonzero.
WARMUP, 16, number of settling cycles discarded after the datapath leaves reset; range 0..255.
LEN_LOG2, 8, log2 of the accumulation window length; range 8..12.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand valid
in_ready  output  1  operand accepted when in_valid && in_ready
in_data  input  8  operand value, probability in_data/256
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid && out_ready
out_data  output  8  result value
busy  output  1  high in every state except IDLE
dp_n_rst  output  1  active-low reset to the sigmoid datapath
dp_x  output  1  bitstream to datapath x
dp_y  input  1  bitstream from datapath y

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, dp_n_rst=0, dp_x=0, LFSR=SEED, counters=0. Reset mid-job abandons the job with no result.
- FSM states: IDLE, CLEAR, WARMUP, ACCUM, DONE.
- IDLE: in_ready=1, dp_n_rst=0, dp_x=0. On the handshake, latch in_data into the operand register and go to CLEAR.
- CLEAR (1 cycle): dp_n_rst=0, LFSR<=SEED, cycle counter<=0, ones counter<=0. Go to WARMUP, or to ACCUM if WARMUP==0.
- WARMUP: dp_n_rst=1, dp_x live, dp_y ignored. Stay WARMUP cycles, then go to ACCUM.
- ACCUM: dp_n_rst=1, dp_x live. Sample dp_y every cycle; ones += dp_y. Stay exactly 2^LEN_LOG2 cycles, then go to DONE.
- DONE: dp_n_rst=0, dp_x=0, out_valid=1, out_data stable. On out_valid && out_ready, drop out_valid and go to IDLE. in_ready stays 0 in DONE, so a new operand is accepted at the earliest in the cycle after the result handshake.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in WARMUP and ACCUM, holds otherwise.
- dp_x is registered: dp_x <= (lfsr < operand), unsigned compare. operand=0 gives constant 0. operand=255 gives 1 except when lfsr==255.
- Ones counter is LEN_LOG2+1 bits wide and never wraps.
- Result without the optional feature: r = ones >> (LEN_LOG2-8); out_data = (r > 255) ? 255 : r. Saturation covers the all-ones window.
- Latency: handshake at edge T → out_valid high from edge T+2+WARMUP+2^LEN_LOG2 (defaults: T+274).
- in_valid while busy is ignored. The producer holds in_data until the handshake.
- out_data holds the last result after the result handshake until the next job's DONE.

Optional Feature:
SIGMOID_SEQ_ROUND_EN: when defined, the result rounds to nearest: r = (ones + 2^(LEN_LOG2-9)) >> (LEN_LOG2-8), then saturates at 255. When undefined, the result truncates as above. Latency is identical in both builds.

Test Plan:
- dp_y tied 1, in_data=8'h40, defaults → out_valid exactly 274 cycles after the handshake, out_data=255 (count 256 saturated); dp_n_rst low in IDLE/CLEAR/DONE, high for 272 cycles.
- dp_y tied 0, then dp_y toggling 0/1 each cycle → out_data=0, then out_data=128; with SIGMOID_SEQ_ROUND_EN, LEN_LOG2=10, toggling → 128.
- in_data=0 then in_data=255 with a bench monitor on dp_x → zero ones on dp_x for 0; dp_x low only on LFSR==255 cycles for 255 (at most 2 per 272-cycle window).
- Integrated with the real sigmoid, in_data=128 → out_data within 128±24; two back-to-back identical jobs → identical out_data (LFSR reseeded).
- out_ready held low 50 cycles in DONE → out_valid and out_data stable, in_ready=0, in_valid pulses ignored; result handshake then fires and in_ready=1 on the next cycle.
- rst asserted for 1 cycle at ACCUM cycle 100 → next cycle IDLE, out_valid=0, dp_n_rst=0; a following job completes with the normal latency.
